// File: rtl/op_counter_pkg.sv
// op_counter_pkg: op codes and op type shared by the op_counter slice
package op_counter_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_HOLD   = 3'd0;
  localparam op_t OP_INC    = 3'd1;
  localparam op_t OP_DEC    = 3'd2;
  localparam op_t OP_DOUBLE = 3'd3;
  localparam op_t OP_HALVE  = 3'd4;
  localparam op_t OP_LOAD   = 3'd5;
  localparam op_t OP_CLEAR  = 3'd6;
endpackage

// File: rtl/op_counter_prescaler.sv
// op_counter_prescaler: emits a tick on every PRESCALE-th step cycle
module op_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic step,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] cnt;
  assign tick = step && cnt == LAST;
  // phase counter: restarts on reset/load/clear, advances only on step cycles
  always_ff @(posedge clk) begin
    if (reset || restart) cnt <= '0;
    else if (step) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/op_counter.sv
// op_counter: multi-op wrap/saturate counter with overflow flags; prescaler under COUNTER_PRESCALE_EN
module op_counter
  import op_counter_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  op_t              op,
  input  logic             sat,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] value,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             match
);
  localparam logic [WIDTH:0] MOD = {1'b0, MAX_VAL} + 1'b1;
  logic             tick, go, nxt_ovf;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   dbl;
`ifdef COUNTER_PRESCALE_EN
  op_counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (op == OP_LOAD || op == OP_CLEAR),
    .step    (en && op >= OP_INC && op <= OP_HALVE),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif
  assign go    = en && tick;
  assign dbl   = {value, 1'b0};
  assign match = value == compare;
  // next value and limit detection; value never exceeds MAX_VAL so one subtraction wraps a double
  always_comb begin
    nxt     = value;
    nxt_ovf = 1'b0;
    case (op)
      OP_INC: if (go) begin
        nxt_ovf = value >= MAX_VAL;
        nxt     = nxt_ovf ? (sat ? MAX_VAL : '0) : value + 1'b1;
      end
      OP_DEC: if (go) begin
        nxt_ovf = value == '0;
        nxt     = nxt_ovf ? (sat ? '0 : MAX_VAL) : value - 1'b1;
      end
      OP_DOUBLE: if (go) begin
        nxt_ovf = dbl > {1'b0, MAX_VAL};
        nxt     = nxt_ovf ? (sat ? MAX_VAL : WIDTH'(dbl - MOD)) : dbl[WIDTH-1:0];
      end
      OP_HALVE: if (go) nxt = value >> 1;
      OP_LOAD:  nxt = load_value > MAX_VAL ? MAX_VAL : load_value;
      OP_CLEAR: nxt = '0;
      default:  nxt = value;
    endcase
  end
  // state registers; CLEAR wipes the sticky flag, any overflow sets it
  always_ff @(posedge clk) begin
    if (reset) begin
      value      <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      value      <= nxt;
      ovf        <= nxt_ovf;
      ovf_sticky <= op == OP_CLEAR ? 1'b0 : ovf_sticky | nxt_ovf;
    end
  end
endmodule

// File: tb/tb_op_counter.sv
// tb_op_counter: directed stimulus, arithmetic model checked every cycle, plus literal spot checks
module tb_op_counter;
  localparam int W = 8, MAXV = 200, PRE = 4;
  logic clk = 0, reset = 1, en = 0, sat = 0;
  logic [2:0] op = 0;
  logic [W-1:0] load_value = 0, compare = 0, value;
  logic ovf, ovf_sticky, match;
  int errors = 0, checks = 0;
  int m_val = 0, m_ovf = 0, m_stk = 0, m_pre = 0, r;
  bit fire;
  op_counter #(.WIDTH(W), .MAX_VAL(8'(MAXV)), .PRESCALE(PRE)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .sat(sat), .load_value(load_value),
    .compare(compare), .value(value), .ovf(ovf), .ovf_sticky(ovf_sticky), .match(match)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: plain integer arithmetic, out-of-range results wrap modulo MAXV+1 or clamp
  always @(posedge clk) begin
    if (reset) begin
      m_val = 0; m_ovf = 0; m_stk = 0; m_pre = 0;
    end else begin
      m_ovf = 0;
      if (op == 5) begin
        m_val = load_value > MAXV ? MAXV : int'(load_value);
        m_pre = 0;
      end else if (op == 6) begin
        m_val = 0; m_stk = 0; m_pre = 0;
      end else if (en && op >= 1 && op <= 4) begin
`ifdef COUNTER_PRESCALE_EN
        m_pre++;
        fire = m_pre == PRE;
        if (fire) m_pre = 0;
`else
        fire = 1;
`endif
        if (fire) begin
          r = op == 1 ? m_val + 1 : op == 2 ? m_val - 1 : op == 3 ? m_val * 2 : m_val / 2;
          if (r > MAXV || r < 0) begin
            m_ovf = 1;
            m_val = sat ? (r < 0 ? 0 : MAXV) : (r < 0 ? r + MAXV + 1 : r - (MAXV + 1));
          end else m_val = r;
        end
      end
      if (m_ovf) m_stk = 1;
    end
  end
  always @(negedge clk) begin
    chk("value", int'(value), m_val);
    chk("ovf", int'(ovf), m_ovf);
    chk("sticky", int'(ovf_sticky), m_stk);
    chk("match", int'(match), int'(m_val == int'(compare)));
  end
  task automatic cyc(bit rs, int o, bit e, bit s, int lv = 0);
    reset = rs; op = 3'(o); en = e; sat = s; load_value = 8'(lv);
    @(posedge clk); #3;
  endtask
  initial begin
    @(posedge clk); #3;
    cyc(1, 0, 0, 0);
    chk("lit reset value", int'(value), 0);
    chk("lit reset sticky", int'(ovf_sticky), 0);
    repeat (5) cyc(0, 1, 1, 0);
`ifndef COUNTER_PRESCALE_EN
    chk("lit inc5", int'(value), 5);
    chk("lit inc5 ovf", int'(ovf), 0);
`endif
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("lit mid reset", int'(value), 0);
    cyc(0, 5, 0, 0, 199);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
`ifndef COUNTER_PRESCALE_EN
    chk("lit wrap inc", int'(value), 0);
    chk("lit wrap ovf", int'(ovf), 1);
`endif
    cyc(0, 5, 0, 1, 199);
    repeat (3) cyc(0, 1, 1, 1);
`ifndef COUNTER_PRESCALE_EN
    chk("lit sat inc", int'(value), 200);
    chk("lit sat ovf", int'(ovf), 1);
    chk("lit sat sticky", int'(ovf_sticky), 1);
`endif
    cyc(0, 6, 0, 0);
    cyc(0, 2, 1, 0);
    cyc(0, 6, 0, 0);
    cyc(0, 2, 1, 1);
    cyc(0, 6, 0, 0);
    chk("lit clear sticky", int'(ovf_sticky), 0);
    cyc(0, 5, 0, 0, 120);
    cyc(0, 3, 1, 0);
`ifndef COUNTER_PRESCALE_EN
    chk("lit double wrap", int'(value), 39);
`endif
    cyc(0, 5, 0, 1, 120);
    cyc(0, 3, 1, 1);
    cyc(0, 4, 1, 1);
`ifndef COUNTER_PRESCALE_EN
    chk("lit halve", int'(value), 100);
`endif
    cyc(0, 5, 0, 0, 255);
    chk("lit clamp", int'(value), 200);
    compare = 200;
    cyc(0, 1, 0, 0);
    chk("lit match", int'(match), 1);
    chk("lit en0 ovf", int'(ovf), 0);
    cyc(0, 7, 1, 1);
    cyc(0, 0, 1, 0);
    compare = 0;
    cyc(0, 6, 0, 0);
    cyc(0, 3, 1, 0);
    cyc(0, 5, 0, 0, 1);
    cyc(0, 4, 1, 0);
    repeat (4) cyc(0, 4, 1, 0);
    cyc(0, 5, 0, 0, 3);
    repeat (4) cyc(0, 2, 1, 0);
    cyc(0, 6, 0, 0);
    repeat (8) cyc(0, 1, 1, 0);
`ifdef COUNTER_PRESCALE_EN
    chk("lit pre inc8", int'(value), 2);
`else
    chk("lit inc8", int'(value), 8);
`endif
    cyc(0, 6, 0, 0);
    repeat (2) cyc(0, 1, 1, 0);
    cyc(0, 5, 0, 0, 10);
    repeat (3) cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
`ifdef COUNTER_PRESCALE_EN
    chk("lit pre restart", int'(value), 11);
`else
    chk("lit restart", int'(value), 14);
`endif
    repeat (2) cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    repeat (4) cyc(0, 1, 1, 0);
    chk("lit post reset", int'(value), 4 / (`ifdef COUNTER_PRESCALE_EN PRE `else 1 `endif));
    cyc(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
